// File: rtl/iterative_shift_rotate_pkg.sv
// Shared encodings for the iterative shift/rotate unit: operation codes and FSM states.
package iterative_shift_rotate_pkg;

  localparam logic [1:0] SH_SRA  = 2'b00;
  localparam logic [1:0] SH_ROR  = 2'b01;
  localparam logic [1:0] SH_ROL  = 2'b10;
  localparam logic [1:0] SH_RSVD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/iterative_shift_rotate_shift_step.sv
// Single-bit shift/rotate of the working register, selected by the latched operation.
// Reserved operation passes the value through unchanged.
module shift_step
  import iterative_shift_rotate_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] stepped
);

  logic signed [WIDTH-1:0] value_s;

  assign value_s = signed'(value);

  // One-position move of the operand for the selected operation
  always_comb begin
    stepped = value;
    case (op)
      SH_SRA:  stepped = WIDTH'(value_s >>> 1);
      SH_ROR:  stepped = {value[0], value[WIDTH-1:1]};
      SH_ROL:  stepped = {value[WIDTH-2:0], value[WIDTH-1]};
      default: stepped = value;
    endcase
  end

endmodule

// File: rtl/iterative_shift_rotate.sv
// Multi-cycle SRA/ROR/ROL unit: one bit position per clock under a START/BUSY/DONE handshake.
// The working register drives RESULT directly, so the output holds between operations.
module iterative_shift_rotate
  import iterative_shift_rotate_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             START,
  input  logic [1:0]       OP,
  input  logic [WIDTH-1:0] DATA_IN,
  input  logic [7:0]       SHIFT_AMT,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] RESULT
);

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_cnt;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] work_stepped;
  logic             accept;

  // Number of single-bit steps for a request: SRA saturates at WIDTH (all sign bits),
  // rotates wrap modulo WIDTH, reserved is a pass-through with no steps.
  function automatic logic [CNT_W-1:0] eff_count(input logic [1:0] op, input logic [7:0] amt);
    logic [7:0] n;
    n = '0;
    case (op)
      SH_SRA:         n = (amt >= 8'(WIDTH)) ? 8'(WIDTH) : amt;
      SH_ROR, SH_ROL: n = amt % 8'(WIDTH);
      default:        n = '0;
    endcase
    return n[CNT_W-1:0];
  endfunction

  assign accept   = START && ((state == ST_IDLE) || (state == ST_DONE));
  assign load_cnt = eff_count(OP, SHIFT_AMT);

  shift_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .op     (op_reg),
    .value  (work),
    .stepped(work_stepped)
  );

  // FSM state register
  always_ff @(posedge CLK) begin
    if (RESET) state <= ST_IDLE;
    else       state <= state_next;
  end

  // Next-state decode; a zero-step request goes straight to DONE
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (START) state_next = (load_cnt != '0) ? ST_SHIFT : ST_DONE;
        else       state_next = ST_IDLE;
      end
      ST_SHIFT: begin
        if (cnt == CNT_W'(1)) state_next = ST_DONE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: load operand/count on accept, then step and count down while shifting.
  // Reset clears the working register too, so a partial result never leaks out.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      work   <= '0;
      cnt    <= '0;
      op_reg <= SH_SRA;
    end else if (accept) begin
      work   <= DATA_IN;
      cnt    <= load_cnt;
      op_reg <= OP;
    end else if (state == ST_SHIFT) begin
      work   <= work_stepped;
      cnt    <= cnt - CNT_W'(1);
    end
  end

  assign BUSY   = (state == ST_SHIFT);
  assign DONE   = (state == ST_DONE);
  assign RESULT = work;

endmodule

// File: doc/iterative_shift_rotate.md
Name: iterative_shift_rotate

Overview:
- Multi-cycle shift/rotate unit for the 8-bit ALU. Covers the operations the combinational logical left/right shifter does not provide: arithmetic shift right, rotate right and rotate left.
- Moves the operand one bit position per clock under a START/BUSY/DONE handshake. This keeps the ALU's critical path short.
- Sits beside the logical shifter in the ALU. The CPU control unit stalls on BUSY and takes RESULT on DONE.

Parameters:
- WIDTH, 8, operand/result width in bits.
- CNT_W, 4, width of the internal remaining-shift counter. Must hold WIDTH.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset; sampled on the rising edge of CLK.
- START  input  1  request strobe; accepted only in IDLE or DONE state.
- OP  input  2  operation: 00 SRA, 01 ROR, 10 ROL, 11 reserved.
- DATA_IN  input  WIDTH  operand; sampled on the START-accept edge only.
- SHIFT_AMT  input  8  shift count, unsigned; sampled on the START-accept edge only.
- BUSY  output  1  high while shifting (SHIFT state).
- DONE  output  1  one-cycle pulse; RESULT is valid from this cycle on.
- RESULT  output  WIDTH  final value; held until the next accepted START or RESET.

Behaviour:
- Reset: RESET high at an edge forces state IDLE, RESULT=0, BUSY=0, DONE=0 and clears the internal count and op registers. Reset has priority over everything, including mid-operation; a partial result is discarded and no DONE is issued.
- States: IDLE, SHIFT, DONE.
- IDLE: BUSY=0, DONE=0. START=1 at an edge accepts the request:
  - latch OP into the op register; load the working register (which drives RESULT) with DATA_IN;
  - latch the effective count n into the counter;
  - next state is SHIFT if n>0, else DONE.
- Effective count n:
  - SRA: n = min(SHIFT_AMT, WIDTH). Amounts of WIDTH or more saturate, giving all sign bits.
  - ROR/ROL: n = SHIFT_AMT mod WIDTH, so 8 or 16 behave as 0.
  - OP=11: n = 0, RESULT = DATA_IN (pass-through, no error flag).
- SHIFT: BUSY=1, DONE=0. Each edge applies one step to the working register and decrements the counter. Steps:
  - SRA: {r[7], r[7:1]}
  - ROR: {r[0], r[7:1]}
  - ROL: {r[6:0], r[7]}
  - When the step that takes the counter from 1 to 0 is applied, next state is DONE.
- DONE: DONE=1 and BUSY=0 for exactly one cycle.
  - At the next edge: START=1 accepts a new request with the same loading as IDLE (back-to-back allowed); otherwise go to IDLE.
  - RESULT holds its value through IDLE.
- Latency: START accepted at edge t means DONE is high in the cycle after edge t+n. n=0 gives DONE in the cycle after edge t; the maximum is 9 edges (SRA by 8 or more).
- START while BUSY=1 is ignored; it is not queued. DATA_IN, SHIFT_AMT and OP changes while BUSY have no effect.
- Only SHIFT_AMT[3:0] plus the saturation/modulo rules determine n. Upper bits of SHIFT_AMT matter only for the SRA saturation test (any nonzero bit in [7:3] saturates).
- No combinational path from inputs to outputs. All outputs are registered or decoded from state.

Decomposition:
- Shared ALU package/header holds:
  - OP encodings SH_SRA=2'b00, SH_ROR=2'b01, SH_ROL=2'b10, SH_RSVD=2'b11;
  - state encodings ST_IDLE, ST_SHIFT, ST_DONE.
- One natural sub-module: shift_step. It is a purely combinational single-bit SRA/ROR/ROL of the working register selected by OP, instantiated once inside the FSM datapath.
- The counter and FSM stay in the top module.

Test Plan:
- Reset, then SRA: DATA_IN=0x90, SHIFT_AMT=2 -> BUSY high 2 cycles; DONE in the cycle after edge t+2; RESULT=0xE4.
- ROR 0x81 by 1 -> RESULT=0xC0. ROL 0x81 by 3 -> RESULT=0x0C. ROR 0x01 by 10 (mod 8 = 2) -> RESULT=0x40.
- SRA 0x80 by 9 -> saturates to 8, DONE after 9 edges, RESULT=0xFF. SRA 0x7F by 200 -> RESULT=0x00.
- SHIFT_AMT=0, and separately OP=11 -> BUSY never asserts; DONE in the cycle after the accept edge; RESULT=DATA_IN (0x5A).
- START re-pulsed during BUSY with a different DATA_IN -> ignored, first result is unchanged. START held high in the DONE cycle -> second operation accepted back-to-back with correct result.
- RESET asserted mid-SHIFT (SRA 0xF0 by 6, after 3 steps) -> next cycle: IDLE, RESULT=0x00, BUSY=0, no DONE pulse. A fresh START then operates normally.
